cache_repl_ctrl: RTL

Replacement-side access controller for a set-associative cache: it is the initiator that drives the PLRU tracker's update port (valid/index/ask_way) and consumes its lru_way answer. On an m1-stage hit it records the hit way in the same cycle. On a miss it latches the PLRU victim, runs the refill bus handshake, writes the returned beats into the victim way, and records the victim when the final refill beat arrives. It sits between the m1 lookup stage, the PLRU instance and the refill bus port.

---
 rtl/cache_repl_ctrl_pkg.sv | 29 ++
 rtl/cache_repl_ctrl.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/cache_repl_ctrl_pkg.sv
// Shared cache package: replacement-controller state encoding, default
// geometry constants and the typedefs that go with that default geometry.
package cache_repl_ctrl_pkg;

    localparam int unsigned SET_SIZE_DEF    = 4;
    localparam int unsigned GROUP_NUM_DEF   = 128;
    localparam int unsigned LINE_WORDS      = 4;
    localparam int unsigned WAY_WIDTH_DEF   = $clog2(SET_SIZE_DEF);
    localparam int unsigned INDEX_WIDTH_DEF = $clog2(GROUP_NUM_DEF);
    localparam int unsigned BEAT_WIDTH_DEF  = $clog2(LINE_WORDS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MISS   = 2'd1,
        REFILL = 2'd2,
        DONE   = 2'd3
    } state_e;

    typedef logic [WAY_WIDTH_DEF-1:0]   way_t;
    typedef logic [INDEX_WIDTH_DEF-1:0] index_t;
    typedef logic [BEAT_WIDTH_DEF-1:0]  beat_t;

    // True when a beat counter value addresses the final word of a line.
    function automatic logic beat_is_final(input logic [31:0] beat,
                                           input int unsigned  line_words);
        return (beat == 32'(line_words - 32'd1));
    endfunction

endpackage

// File: rtl/cache_repl_ctrl.sv
// Replacement-side access controller. Drives the PLRU update port for m1 hits,
// and on a miss latches the PLRU victim, runs the refill read handshake,
// writes returned beats into the victim way and records the victim as
// most-recently-used on the final beat.
module cache_repl_ctrl
    import cache_repl_ctrl_pkg::*;
#(
    parameter int unsigned SET_SIZE    = 4,
    parameter int unsigned GROUP_NUM   = 128,
    parameter int unsigned LINE_WORDS  = 4,
    parameter int unsigned WAY_WIDTH   = $clog2(SET_SIZE),
    parameter int unsigned INDEX_WIDTH = $clog2(GROUP_NUM),
    parameter int unsigned BEAT_WIDTH  = $clog2(LINE_WORDS)
) (
    input  logic                   clk,
    input  logic                   resetn,
    // m1 lookup stage
    input  logic                   req_valid,
    input  logic [INDEX_WIDTH-1:0] req_index,
    input  logic                   hit,
    input  logic [WAY_WIDTH-1:0]   hit_way,
    output logic                   req_stall,
    // PLRU tracker
    input  logic [WAY_WIDTH-1:0]   lru_way,
    output logic                   upd_valid,
    output logic [INDEX_WIDTH-1:0] upd_index,
    output logic [WAY_WIDTH-1:0]   upd_way,
    // refill bus
    output logic                   rd_req,
    output logic [INDEX_WIDTH-1:0] rd_index,
    input  logic                   rd_rdy,
    input  logic                   ret_valid,
    input  logic                   ret_last,
    // data array write port
    output logic                   refill_we,
    output logic [WAY_WIDTH-1:0]   refill_way,
    output logic [BEAT_WIDTH-1:0]  refill_word,
    output logic                   refill_done
);

    state_e                 state_q,      state_d;
    logic [INDEX_WIDTH-1:0] miss_index_q, miss_index_d;
    logic [WAY_WIDTH-1:0]   victim_q,     victim_d;
    logic [BEAT_WIDTH-1:0]  beat_q,       beat_d;
    // Set once the last word of the line has been written; further beats
    // without ret_last are dropped instead of overwriting word 0 again.
    logic                   full_q,       full_d;

    // State and datapath registers, cleared asynchronously so a reset aborts
    // any refill in flight.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            miss_index_q <= '0;
            victim_q     <= '0;
            beat_q       <= '0;
            full_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            miss_index_q <= miss_index_d;
            victim_q     <= victim_d;
            beat_q       <= beat_d;
            full_q       <= full_d;
        end
    end

    // Next-state and datapath update: capture the miss context, advance the
    // beat counter (saturating at the final word) and sequence the refill.
    always_comb begin
        state_d      = state_q;
        miss_index_d = miss_index_q;
        victim_d     = victim_q;
        beat_d       = beat_q;
        full_d       = full_q;
        case (state_q)
            IDLE: begin
                if (req_valid && !hit) begin
                    state_d      = MISS;
                    miss_index_d = req_index;
                    victim_d     = lru_way;
                    beat_d       = '0;
                    full_d       = 1'b0;
                end else begin
                    state_d      = IDLE;
                end
            end
            MISS: begin
                // Beats arriving alongside rd_rdy are not yet accepted.
                if (rd_rdy) begin
                    state_d = REFILL;
                end else begin
                    state_d = MISS;
                end
            end
            REFILL: begin
                if (ret_valid) begin
                    if (full_q) begin
                        beat_d = beat_q;
                    end else if (beat_is_final(32'(beat_q), LINE_WORDS)) begin
                        full_d = 1'b1;
                    end else begin
                        beat_d = beat_q + BEAT_WIDTH'(1);
                    end
                    if (ret_last) begin
                        state_d = DONE;
                    end else begin
                        state_d = REFILL;
                    end
                end else begin
                    state_d = REFILL;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode. Outside IDLE the PLRU index stays on the missing set so
    // lru_way for an unrelated set is never consumed.
    always_comb begin
        req_stall   = 1'b1;
        upd_valid   = 1'b0;
        upd_index   = miss_index_q;
        upd_way     = victim_q;
        rd_req      = 1'b0;
        rd_index    = miss_index_q;
        refill_we   = 1'b0;
        refill_way  = victim_q;
        refill_word = beat_q;
        refill_done = 1'b0;
        case (state_q)
            IDLE: begin
                req_stall = req_valid & ~hit;
                upd_valid = req_valid & hit;
                upd_index = req_index;
                upd_way   = hit_way;
            end
            MISS: begin
                rd_req = 1'b1;
            end
            REFILL: begin
                refill_we = ret_valid & ~full_q;
                upd_valid = ret_valid & ret_last;
            end
            DONE: begin
                refill_done = 1'b1;
            end
            default: begin
                req_stall = 1'b1;
            end
        endcase
    end

endmodule
